// File: rtl/dispatch_router_pkg.sv
// Shared types and constants for the dispatch router: request/payload layouts,
// unit select encodings and the router's sticky error codes.
package dispatch_router_pkg;

    localparam int REQ_W = 103;
    localparam int PAY_W = 100;
    localparam int CNT_W = 32;

    localparam logic [31:0] KIANA_SP_ERR_ROUTER_NO_UNIT    = 32'h0000_0001;
    localparam logic [31:0] KIANA_SP_ERR_ROUTER_MULTI_UNIT = 32'h0000_0002;

    localparam logic [2:0] SEL_ALU = 3'b100;
    localparam logic [2:0] SEL_LSU = 3'b010;
    localparam logic [2:0] SEL_SP  = 3'b001;

    typedef struct packed {
        logic [4:0]  warp;
        logic [62:0] instr;
        logic [31:0] pred;
        logic        alu;
        logic        lsu;
        logic        sp;
    } dispatch_req_t;

    typedef struct packed {
        logic [4:0]  warp_id;
        logic [62:0] instr;
        logic [31:0] pred;
    } unit_payload_t;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    function automatic logic sel_is_multi(input logic [2:0] sel);
        return (sel[2] & sel[1]) | (sel[2] & sel[0]) | (sel[1] & sel[0]);
    endfunction

endpackage

// File: rtl/dispatch_slot.sv
// One-entry registered valid/ready output slot feeding a single execution unit.
module dispatch_slot
    import dispatch_router_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [PAY_W-1:0] load_data_i,
    input  logic             m_tready_i,
    output logic             m_tvalid_o,
    output logic [PAY_W-1:0] m_data_o,
    output logic             full_o,
    output logic             can_load_o
);

    slot_state_e      state_q, state_d;
    logic [PAY_W-1:0] data_q, data_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    // A load always wins over a drain so a full slot can refill in the cycle it empties.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        unique case (state_q)
            SLOT_EMPTY: begin
                if (load_i) begin
                    state_d = SLOT_FULL;
                    data_d  = load_data_i;
                end
            end
            SLOT_FULL: begin
                if (load_i) begin
                    state_d = SLOT_FULL;
                    data_d  = load_data_i;
                end else if (m_tready_i) begin
                    state_d = SLOT_EMPTY;
                end
            end
            default: state_d = SLOT_EMPTY;
        endcase
    end

    assign full_o     = (state_q == SLOT_FULL);
    assign m_tvalid_o = full_o;
    assign m_data_o   = data_q;
    assign can_load_o = ~full_o | m_tready_i;

endmodule

// File: rtl/dispatch_router.sv
// Pops dispatch requests from the scheduler FIFO and routes each to the ALU, LSU
// or special-unit output slot; tracks sticky decode errors and per-unit issue counts.
module dispatch_router
    import dispatch_router_pkg::*;
(
    input  logic             clk,
    input  logic             rst,

    input  logic             s_tvalid_req,
    output logic             s_tready_req,
    input  logic [REQ_W-1:0] s_req_data,

    output logic             m_tvalid_alu_u,
    input  logic             m_tready_alu_u,
    output logic [PAY_W-1:0] m_alu_data,

    output logic             m_tvalid_lsu_u,
    input  logic             m_tready_lsu_u,
    output logic [PAY_W-1:0] m_lsu_data,

    output logic             m_tvalid_sp_u,
    input  logic             m_tready_sp_u,
    output logic [PAY_W-1:0] m_sp_data,

    output logic             m_tready_alu,
    output logic             m_tready_lsu,
    output logic             m_tready_special,

    output logic [31:0]      err,
    input  logic             err_clr,

    output logic [CNT_W-1:0] issue_cnt_alu,
    output logic [CNT_W-1:0] issue_cnt_lsu,
    output logic [CNT_W-1:0] issue_cnt_sp
);

    dispatch_req_t    req;
    unit_payload_t    payload;
    logic [2:0]       sel;
    logic             is_alu, is_lsu, is_sp, illegal;
    logic             target_can_load, pop;
    logic             load_alu, load_lsu, load_sp;
    logic             full_alu, full_lsu, full_sp;
    logic             cl_alu, cl_lsu, cl_sp;
    logic [31:0]      err_q, err_d, err_new;
    logic [CNT_W-1:0] cnt_alu_q, cnt_alu_d;
    logic [CNT_W-1:0] cnt_lsu_q, cnt_lsu_d;
    logic [CNT_W-1:0] cnt_sp_q, cnt_sp_d;

    assign req     = dispatch_req_t'(s_req_data);
    assign sel     = {req.alu, req.lsu, req.sp};
    assign payload = '{warp_id: req.warp, instr: req.instr, pred: req.pred};

    assign is_alu  = (sel == SEL_ALU);
    assign is_lsu  = (sel == SEL_LSU);
    assign is_sp   = (sel == SEL_SP);
    assign illegal = ~(is_alu | is_lsu | is_sp);

    // Illegal selects are always popped and dropped so a bad word never wedges the FIFO.
    always_comb begin
        target_can_load = 1'b0;
        if (is_alu)      target_can_load = cl_alu;
        else if (is_lsu) target_can_load = cl_lsu;
        else if (is_sp)  target_can_load = cl_sp;
    end

    assign s_tready_req = ~rst & (illegal | target_can_load);
    assign pop          = s_tvalid_req & s_tready_req;
    assign load_alu     = pop & is_alu;
    assign load_lsu     = pop & is_lsu;
    assign load_sp      = pop & is_sp;

    dispatch_slot u_slot_alu (
        .clk         (clk),
        .rst         (rst),
        .load_i      (load_alu),
        .load_data_i (payload),
        .m_tready_i  (m_tready_alu_u),
        .m_tvalid_o  (m_tvalid_alu_u),
        .m_data_o    (m_alu_data),
        .full_o      (full_alu),
        .can_load_o  (cl_alu)
    );

    dispatch_slot u_slot_lsu (
        .clk         (clk),
        .rst         (rst),
        .load_i      (load_lsu),
        .load_data_i (payload),
        .m_tready_i  (m_tready_lsu_u),
        .m_tvalid_o  (m_tvalid_lsu_u),
        .m_data_o    (m_lsu_data),
        .full_o      (full_lsu),
        .can_load_o  (cl_lsu)
    );

    dispatch_slot u_slot_sp (
        .clk         (clk),
        .rst         (rst),
        .load_i      (load_sp),
        .load_data_i (payload),
        .m_tready_i  (m_tready_sp_u),
        .m_tvalid_o  (m_tvalid_sp_u),
        .m_data_o    (m_sp_data),
        .full_o      (full_sp),
        .can_load_o  (cl_sp)
    );

    // Scheduler-facing ready uses registered state only, never the unit's same-cycle drain.
    assign m_tready_alu     = ~full_alu;
    assign m_tready_lsu     = ~full_lsu;
    assign m_tready_special = ~full_sp;

    always_comb begin
        err_new = '0;
        if (pop && illegal) begin
            if (sel == 3'b000)          err_new = KIANA_SP_ERR_ROUTER_NO_UNIT;
            else if (sel_is_multi(sel)) err_new = KIANA_SP_ERR_ROUTER_MULTI_UNIT;
        end
        err_d = err_clr ? err_new : (err_q | err_new);
    end

    always_comb begin
        cnt_alu_d = cnt_alu_q;
        cnt_lsu_d = cnt_lsu_q;
        cnt_sp_d  = cnt_sp_q;
        if (m_tvalid_alu_u && m_tready_alu_u) cnt_alu_d = cnt_alu_q + 1'b1;
        if (m_tvalid_lsu_u && m_tready_lsu_u) cnt_lsu_d = cnt_lsu_q + 1'b1;
        if (m_tvalid_sp_u  && m_tready_sp_u)  cnt_sp_d  = cnt_sp_q  + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q     <= '0;
            cnt_alu_q <= '0;
            cnt_lsu_q <= '0;
            cnt_sp_q  <= '0;
        end else begin
            err_q     <= err_d;
            cnt_alu_q <= cnt_alu_d;
            cnt_lsu_q <= cnt_lsu_d;
            cnt_sp_q  <= cnt_sp_d;
        end
    end

    assign err           = err_q;
    assign issue_cnt_alu = cnt_alu_q;
    assign issue_cnt_lsu = cnt_lsu_q;
    assign issue_cnt_sp  = cnt_sp_q;

endmodule

// File: tb/tb_dispatch_router.sv
// Directed self-checking bench for dispatch_router: routing, back-pressure,
// illegal selects, error clearing, mid-run reset and sustained throughput.
module tb_dispatch_router;

    logic         clk = 1'b0;
    logic         rst;
    logic         s_tvalid_req;
    logic         s_tready_req;
    logic [102:0] s_req_data;
    logic         m_tvalid_alu_u, m_tready_alu_u;
    logic [99:0]  m_alu_data;
    logic         m_tvalid_lsu_u, m_tready_lsu_u;
    logic [99:0]  m_lsu_data;
    logic         m_tvalid_sp_u, m_tready_sp_u;
    logic [99:0]  m_sp_data;
    logic         m_tready_alu, m_tready_lsu, m_tready_special;
    logic [31:0]  err;
    logic         err_clr;
    logic [31:0]  issue_cnt_alu, issue_cnt_lsu, issue_cnt_sp;

    int checks   = 0;
    int failures = 0;

    localparam logic [31:0] E_NO    = 32'h0000_0001;
    localparam logic [31:0] E_MULTI = 32'h0000_0002;

    always #5 clk = ~clk;

    dispatch_router dut (
        .clk              (clk),
        .rst              (rst),
        .s_tvalid_req     (s_tvalid_req),
        .s_tready_req     (s_tready_req),
        .s_req_data       (s_req_data),
        .m_tvalid_alu_u   (m_tvalid_alu_u),
        .m_tready_alu_u   (m_tready_alu_u),
        .m_alu_data       (m_alu_data),
        .m_tvalid_lsu_u   (m_tvalid_lsu_u),
        .m_tready_lsu_u   (m_tready_lsu_u),
        .m_lsu_data       (m_lsu_data),
        .m_tvalid_sp_u    (m_tvalid_sp_u),
        .m_tready_sp_u    (m_tready_sp_u),
        .m_sp_data        (m_sp_data),
        .m_tready_alu     (m_tready_alu),
        .m_tready_lsu     (m_tready_lsu),
        .m_tready_special (m_tready_special),
        .err              (err),
        .err_clr          (err_clr),
        .issue_cnt_alu    (issue_cnt_alu),
        .issue_cnt_lsu    (issue_cnt_lsu),
        .issue_cnt_sp     (issue_cnt_sp)
    );

    function automatic logic [102:0] mk_req(input logic [4:0] w, input logic [62:0] ins,
                                            input logic [31:0] p, input logic [2:0] s);
        return {w, ins, p, s};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; err_clr = 1'b0;
        m_tready_alu_u = 1'b0; m_tready_lsu_u = 1'b0; m_tready_sp_u = 1'b0;
        s_tvalid_req = 1'b1;
        s_req_data = mk_req(5'd1, 63'd7, 32'd1, 3'b100);
        tick(); tick();
        checks++; if (s_tready_req !== 1'b0) begin failures++; $display("[TB] FAIL rst_s_tready got=%b exp=0", s_tready_req); end
        checks++; if ({m_tvalid_alu_u, m_tvalid_lsu_u, m_tvalid_sp_u} !== 3'b000) begin failures++; $display("[TB] FAIL rst_valids got=%b exp=000", {m_tvalid_alu_u, m_tvalid_lsu_u, m_tvalid_sp_u}); end
        checks++; if ({m_alu_data, m_lsu_data, m_sp_data} !== 300'd0) begin failures++; $display("[TB] FAIL rst_payloads not zero"); end
        checks++; if ({m_tready_alu, m_tready_lsu, m_tready_special} !== 3'b111) begin failures++; $display("[TB] FAIL rst_sched_ready got=%b exp=111", {m_tready_alu, m_tready_lsu, m_tready_special}); end
        checks++; if (err !== 32'd0) begin failures++; $display("[TB] FAIL rst_err got=%h exp=0", err); end
        checks++; if ({issue_cnt_alu, issue_cnt_lsu, issue_cnt_sp} !== 96'd0) begin failures++; $display("[TB] FAIL rst_counters got=%0d/%0d/%0d exp=0/0/0", issue_cnt_alu, issue_cnt_lsu, issue_cnt_sp); end
        s_tvalid_req = 1'b0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_alu();
        m_tready_alu_u = 1'b1;
        s_req_data = mk_req(5'd5, 63'h1234, 32'hFFFF_FFFF, 3'b100);
        s_tvalid_req = 1'b1;
        #1;
        checks++; if (s_tready_req !== 1'b1) begin failures++; $display("[TB] FAIL alu_pop_ready got=%b exp=1", s_tready_req); end
        tick();
        s_tvalid_req = 1'b0;
        checks++; if (m_tvalid_alu_u !== 1'b1) begin failures++; $display("[TB] FAIL alu_valid got=%b exp=1", m_tvalid_alu_u); end
        checks++; if (m_alu_data[99:95] !== 5'd5) begin failures++; $display("[TB] FAIL alu_warp got=%0d exp=5", m_alu_data[99:95]); end
        checks++; if (m_alu_data !== {5'd5, 63'h1234, 32'hFFFF_FFFF}) begin failures++; $display("[TB] FAIL alu_payload got=%h", m_alu_data); end
        checks++; if (m_tready_alu !== 1'b0) begin failures++; $display("[TB] FAIL alu_sched_ready_full got=%b exp=0", m_tready_alu); end
        tick();
        checks++; if (issue_cnt_alu !== 32'd1) begin failures++; $display("[TB] FAIL alu_count got=%0d exp=1", issue_cnt_alu); end
        checks++; if (m_tvalid_alu_u !== 1'b0) begin failures++; $display("[TB] FAIL alu_drained got=%b exp=0", m_tvalid_alu_u); end
        checks++; if (m_tready_alu !== 1'b1) begin failures++; $display("[TB] FAIL alu_sched_ready_empty got=%b exp=1", m_tready_alu); end
    endtask

    task automatic test_back_pressure();
        m_tready_lsu_u = 1'b0;
        s_req_data = mk_req(5'd3, 63'h0AAA, 32'h0000_00F0, 3'b010);
        s_tvalid_req = 1'b1;
        tick();
        s_req_data = mk_req(5'd4, 63'h0BBB, 32'h0000_0F00, 3'b010);
        #1;
        checks++; if (s_tready_req !== 1'b0) begin failures++; $display("[TB] FAIL bp_fifo_blocked got=%b exp=0", s_tready_req); end
        checks++; if (m_tready_lsu !== 1'b0) begin failures++; $display("[TB] FAIL bp_sched_ready got=%b exp=0", m_tready_lsu); end
        checks++; if (m_lsu_data !== {5'd3, 63'h0AAA, 32'h0000_00F0} || m_tvalid_lsu_u !== 1'b1) begin failures++; $display("[TB] FAIL bp_first_held got=%b/%h", m_tvalid_lsu_u, m_lsu_data); end
        tick();
        checks++; if (m_lsu_data !== {5'd3, 63'h0AAA, 32'h0000_00F0}) begin failures++; $display("[TB] FAIL bp_hold_stable got=%h", m_lsu_data); end
        m_tready_lsu_u = 1'b1;
        #1;
        checks++; if (s_tready_req !== 1'b1) begin failures++; $display("[TB] FAIL bp_passthrough_ready got=%b exp=1", s_tready_req); end
        tick();
        s_tvalid_req = 1'b0;
        checks++; if (m_tvalid_lsu_u !== 1'b1 || m_lsu_data !== {5'd4, 63'h0BBB, 32'h0000_0F00}) begin failures++; $display("[TB] FAIL bp_no_bubble got=%b/%h", m_tvalid_lsu_u, m_lsu_data); end
        checks++; if (issue_cnt_lsu !== 32'd1) begin failures++; $display("[TB] FAIL bp_count1 got=%0d exp=1", issue_cnt_lsu); end
        tick();
        checks++; if (issue_cnt_lsu !== 32'd2 || m_tvalid_lsu_u !== 1'b0) begin failures++; $display("[TB] FAIL bp_count2 got=%0d/%b exp=2/0", issue_cnt_lsu, m_tvalid_lsu_u); end
    endtask

    task automatic test_interleave();
        m_tready_alu_u = 1'b1; m_tready_lsu_u = 1'b1; m_tready_sp_u = 1'b0;
        s_tvalid_req = 1'b1;
        s_req_data = mk_req(5'd7, 63'h11, 32'h1, 3'b100);
        tick();
        s_req_data = mk_req(5'd8, 63'h22, 32'h0, 3'b010);
        tick();
        checks++; if (m_lsu_data !== {5'd8, 63'h22, 32'h0} || m_tvalid_lsu_u !== 1'b1) begin failures++; $display("[TB] FAIL il_pred0_forwarded got=%b/%h", m_tvalid_lsu_u, m_lsu_data); end
        s_req_data = mk_req(5'd9, 63'h33, 32'hF, 3'b001);
        tick();
        s_req_data = mk_req(5'd10, 63'h44, 32'hFF, 3'b001);
        #1;
        checks++; if (s_tready_req !== 1'b0) begin failures++; $display("[TB] FAIL il_sp_blocks_fifo got=%b exp=0", s_tready_req); end
        checks++; if (m_tvalid_sp_u !== 1'b1 || m_sp_data !== {5'd9, 63'h33, 32'hF} || m_tready_special !== 1'b0) begin failures++; $display("[TB] FAIL il_sp_held got=%b/%h/%b", m_tvalid_sp_u, m_sp_data, m_tready_special); end
        checks++; if ({m_tvalid_alu_u, m_tvalid_lsu_u, m_tready_alu, m_tready_lsu} !== 4'b0011) begin failures++; $display("[TB] FAIL il_others_drained got=%b exp=0011", {m_tvalid_alu_u, m_tvalid_lsu_u, m_tready_alu, m_tready_lsu}); end
        checks++; if (issue_cnt_alu !== 32'd2 || issue_cnt_lsu !== 32'd3) begin failures++; $display("[TB] FAIL il_counts got=%0d/%0d exp=2/3", issue_cnt_alu, issue_cnt_lsu); end
        tick(); tick();
        checks++; if (m_sp_data !== {5'd9, 63'h33, 32'hF} || issue_cnt_sp !== 32'd0) begin failures++; $display("[TB] FAIL il_sp_stall got=%h/%0d", m_sp_data, issue_cnt_sp); end
        m_tready_sp_u = 1'b1;
        tick();
        s_tvalid_req = 1'b0;
        checks++; if (m_sp_data !== {5'd10, 63'h44, 32'hFF} || issue_cnt_sp !== 32'd1) begin failures++; $display("[TB] FAIL il_sp_reload got=%h/%0d", m_sp_data, issue_cnt_sp); end
        tick();
        checks++; if (issue_cnt_sp !== 32'd2 || m_tvalid_sp_u !== 1'b0) begin failures++; $display("[TB] FAIL il_sp_done got=%0d/%b exp=2/0", issue_cnt_sp, m_tvalid_sp_u); end
    endtask

    task automatic test_illegal();
        s_req_data = mk_req(5'd1, 63'h55, 32'h1, 3'b000);
        s_tvalid_req = 1'b1;
        #1;
        checks++; if (s_tready_req !== 1'b1) begin failures++; $display("[TB] FAIL ill_pop_ready got=%b exp=1", s_tready_req); end
        tick();
        checks++; if (err !== E_NO) begin failures++; $display("[TB] FAIL ill_no_unit got=%h exp=%h", err, E_NO); end
        s_req_data = mk_req(5'd2, 63'h66, 32'h2, 3'b110);
        tick();
        checks++; if (err !== (E_NO | E_MULTI)) begin failures++; $display("[TB] FAIL ill_both got=%h exp=%h", err, E_NO | E_MULTI); end
        checks++; if ({m_tvalid_alu_u, m_tvalid_lsu_u, m_tvalid_sp_u} !== 3'b000) begin failures++; $display("[TB] FAIL ill_no_valid got=%b exp=000", {m_tvalid_alu_u, m_tvalid_lsu_u, m_tvalid_sp_u}); end
        s_req_data = mk_req(5'd3, 63'h77, 32'h3, 3'b011);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        s_tvalid_req = 1'b0;
        checks++; if (err !== E_MULTI) begin failures++; $display("[TB] FAIL ill_clr_keeps_new got=%h exp=%h", err, E_MULTI); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++; if (err !== 32'd0) begin failures++; $display("[TB] FAIL ill_clr got=%h exp=0", err); end
    endtask

    task automatic test_reset_mid();
        m_tready_alu_u = 1'b0; m_tready_lsu_u = 1'b0; m_tready_sp_u = 1'b0;
        s_tvalid_req = 1'b1;
        s_req_data = mk_req(5'd11, 63'h1, 32'h1, 3'b100);
        tick();
        s_req_data = mk_req(5'd12, 63'h2, 32'h2, 3'b010);
        tick();
        s_req_data = mk_req(5'd13, 63'h3, 32'h3, 3'b001);
        tick();
        checks++; if ({m_tvalid_alu_u, m_tvalid_lsu_u, m_tvalid_sp_u} !== 3'b111) begin failures++; $display("[TB] FAIL rm_all_full got=%b exp=111", {m_tvalid_alu_u, m_tvalid_lsu_u, m_tvalid_sp_u}); end
        s_req_data = mk_req(5'd14, 63'h4, 32'h4, 3'b100);
        m_tready_alu_u = 1'b1;
        rst = 1'b1;
        #1;
        checks++; if (s_tready_req !== 1'b0) begin failures++; $display("[TB] FAIL rm_no_pop got=%b exp=0", s_tready_req); end
        tick();
        checks++; if ({m_tvalid_alu_u, m_tvalid_lsu_u, m_tvalid_sp_u} !== 3'b000) begin failures++; $display("[TB] FAIL rm_valids got=%b exp=000", {m_tvalid_alu_u, m_tvalid_lsu_u, m_tvalid_sp_u}); end
        checks++; if ({issue_cnt_alu, issue_cnt_lsu, issue_cnt_sp} !== 96'd0) begin failures++; $display("[TB] FAIL rm_counters got=%0d/%0d/%0d exp=0/0/0", issue_cnt_alu, issue_cnt_lsu, issue_cnt_sp); end
        checks++; if ({m_tready_alu, m_tready_lsu, m_tready_special} !== 3'b111) begin failures++; $display("[TB] FAIL rm_sched_ready got=%b exp=111", {m_tready_alu, m_tready_lsu, m_tready_special}); end
        s_tvalid_req = 1'b0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_throughput();
        logic [99:0]  qa[$], ql[$], qs[$];
        logic [99:0]  exp_pay;
        logic [102:0] req;
        logic [63:0]  r64;
        logic [2:0]   sel;
        int           na, nl, ns, u;
        na = 0; nl = 0; ns = 0;
        m_tready_alu_u = 1'b1; m_tready_lsu_u = 1'b1; m_tready_sp_u = 1'b1;
        for (int i = 0; i < 100; i++) begin
            u   = int'($urandom_range(0, 2));
            sel = (u == 0) ? 3'b100 : (u == 1) ? 3'b010 : 3'b001;
            r64 = {$urandom, $urandom};
            req = mk_req(5'($urandom), r64[62:0], $urandom, sel);
            exp_pay = req[102:3];
            if (u == 0) begin qa.push_back(exp_pay); na++; end
            else if (u == 1) begin ql.push_back(exp_pay); nl++; end
            else begin qs.push_back(exp_pay); ns++; end
            s_req_data   = req;
            s_tvalid_req = 1'b1;
            #1;
            checks++; if (s_tready_req !== 1'b1) begin failures++; $display("[TB] FAIL tp_pop_%0d got=%b exp=1", i, s_tready_req); end
            tick();
            checks++; if ($countones({m_tvalid_alu_u, m_tvalid_lsu_u, m_tvalid_sp_u}) != 1) begin failures++; $display("[TB] FAIL tp_one_valid_%0d got=%b", i, {m_tvalid_alu_u, m_tvalid_lsu_u, m_tvalid_sp_u}); end
            if (m_tvalid_alu_u) begin
                checks++;
                if (qa.size() == 0) begin failures++; $display("[TB] FAIL tp_alu_extra_%0d got=%h", i, m_alu_data); end
                else begin exp_pay = qa.pop_front(); if (m_alu_data !== exp_pay) begin failures++; $display("[TB] FAIL tp_alu_%0d got=%h exp=%h", i, m_alu_data, exp_pay); end end
            end
            if (m_tvalid_lsu_u) begin
                checks++;
                if (ql.size() == 0) begin failures++; $display("[TB] FAIL tp_lsu_extra_%0d got=%h", i, m_lsu_data); end
                else begin exp_pay = ql.pop_front(); if (m_lsu_data !== exp_pay) begin failures++; $display("[TB] FAIL tp_lsu_%0d got=%h exp=%h", i, m_lsu_data, exp_pay); end end
            end
            if (m_tvalid_sp_u) begin
                checks++;
                if (qs.size() == 0) begin failures++; $display("[TB] FAIL tp_sp_extra_%0d got=%h", i, m_sp_data); end
                else begin exp_pay = qs.pop_front(); if (m_sp_data !== exp_pay) begin failures++; $display("[TB] FAIL tp_sp_%0d got=%h exp=%h", i, m_sp_data, exp_pay); end end
            end
        end
        s_tvalid_req = 1'b0;
        tick();
        checks++; if ({m_tvalid_alu_u, m_tvalid_lsu_u, m_tvalid_sp_u} !== 3'b000) begin failures++; $display("[TB] FAIL tp_idle got=%b exp=000", {m_tvalid_alu_u, m_tvalid_lsu_u, m_tvalid_sp_u}); end
        checks++; if (issue_cnt_alu !== 32'(na) || issue_cnt_lsu !== 32'(nl) || issue_cnt_sp !== 32'(ns)) begin failures++; $display("[TB] FAIL tp_unit_counts got=%0d/%0d/%0d exp=%0d/%0d/%0d", issue_cnt_alu, issue_cnt_lsu, issue_cnt_sp, na, nl, ns); end
        checks++; if (issue_cnt_alu + issue_cnt_lsu + issue_cnt_sp !== 32'd100) begin failures++; $display("[TB] FAIL tp_count_sum got=%0d exp=100", issue_cnt_alu + issue_cnt_lsu + issue_cnt_sp); end
        checks++; if (qa.size() + ql.size() + qs.size() != 0) begin failures++; $display("[TB] FAIL tp_left_over got=%0d exp=0", qa.size() + ql.size() + qs.size()); end
    endtask

    initial begin
        test_reset();
        test_single_alu();
        test_back_pressure();
        test_interleave();
        test_illegal();
        test_reset_mid();
        test_throughput();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
